// File: rtl/lcd_field_scheduler.sv
// Round-robin arbiter feeding an LCD1602 byte path: set-address command then hex digits; address byte 1 cycle after grant, ack 1 cycle after last char.
// Stalls with cmd_valid/cmd_rs/cmd_data held while cmd_ready is low; requests are only sampled in IDLE.
module lcd_field_scheduler #(
   parameter logic [6:0] ADDR0     = 7'h00,
   parameter logic [6:0] ADDR1     = 7'h40,
   parameter bit         HEX_UPPER = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [15:0] number1,
   output logic        ack0,
   input  logic        req1,
   input  logic [3:0]  number2,
   output logic        ack1,
   output logic        cmd_valid,
   output logic        cmd_rs,
   output logic [7:0]  cmd_data,
   input  logic        cmd_ready,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ADDR, CHAR, DONE} state_t;

   state_t      state;
   logic        last;
   logic        client;
   logic [15:0] sh;
   logic [2:0]  len;
   logic [2:0]  idx;
   logic        grant_sel;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else if (HEX_UPPER)
         return 8'h37 + {4'h0, n};
      else
         return 8'h57 + {4'h0, n};
   endfunction

   // On a tie the client that was not served last wins.
   always_comb begin
      grant_sel = (req0 && req1) ? ~last : req1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         last      <= 1'b1;
         client    <= 1'b0;
         sh        <= '0;
         len       <= '0;
         idx       <= '0;
         cmd_valid <= 1'b0;
         cmd_rs    <= 1'b0;
         cmd_data  <= '0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  client    <= grant_sel;
                  last      <= grant_sel;
                  len       <= grant_sel ? 3'd1 : 3'd4;
                  // Digits are shifted out of the top nibble, so client 1's digit is left-aligned.
                  sh        <= grant_sel ? {number2, 12'h000} : number1;
                  idx       <= '0;
                  cmd_valid <= 1'b1;
                  cmd_rs    <= 1'b0;
                  cmd_data  <= {1'b1, (grant_sel ? ADDR1 : ADDR0)};
                  busy      <= 1'b1;
                  state     <= ADDR;
               end
            end
            ADDR: begin
               if (cmd_ready) begin
                  cmd_rs   <= 1'b1;
                  cmd_data <= hex_ascii(sh[15:12]);
                  sh       <= {sh[11:0], 4'h0};
                  state    <= CHAR;
               end
            end
            CHAR: begin
               if (cmd_ready) begin
                  idx <= idx + 3'd1;
                  if (idx == len - 3'd1) begin
                     cmd_valid <= 1'b0;
                     cmd_rs    <= 1'b0;
                     cmd_data  <= '0;
                     ack0      <= ~client;
                     ack1      <= client;
                     state     <= DONE;
                  end else begin
                     cmd_data <= hex_ascii(sh[15:12]);
                     sh       <= {sh[11:0], 4'h0};
                  end
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               cmd_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_field_scheduler.sv
// Bench for lcd_field_scheduler: job-level byte-queue model, directed scenarios, random traffic.
module tb_lcd_field_scheduler;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0, cmd_ready = 1'b1;
   logic [15:0] number1 = '0;
   logic [3:0]  number2 = '0;
   logic        ack0, ack1, cmd_valid, cmd_rs, busy;
   logic [7:0]  cmd_data;
   logic        lc_ack0, lc_ack1, lc_valid, lc_rs, lc_busy;
   logic [7:0]  lc_data;

   lcd_field_scheduler dut (
      .clk(clk), .reset(reset), .req0(req0), .number1(number1), .ack0(ack0),
      .req1(req1), .number2(number2), .ack1(ack1), .cmd_valid(cmd_valid),
      .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_ready(cmd_ready), .busy(busy));

   lcd_field_scheduler #(.HEX_UPPER(1'b0)) dut_lc (
      .clk(clk), .reset(reset), .req0(req0), .number1(number1), .ack0(lc_ack0),
      .req1(req1), .number2(number2), .ack1(lc_ack1), .cmd_valid(lc_valid),
      .cmd_rs(lc_rs), .cmd_data(lc_data), .cmd_ready(cmd_ready), .busy(lc_busy));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [8:0] log_q[$];
   logic [8:0] lc_q[$];

   function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model: one job = a queue of {rs,byte} ----------------
   bit         m_job, m_done, m_client, m_last;
   int         m_pos;
   logic [8:0] m_bytes[$];

   function automatic logic [7:0] asc(input logic [3:0] n);
      if (n <= 4'd9) return 8'h30 + {4'h0, n};
      return 8'h41 + ({4'h0, n} - 8'd10);
   endfunction

   function automatic logic [8:0] lower(input logic [8:0] b);
      if (b[8] && b[7:0] >= 8'h41 && b[7:0] <= 8'h46) return b + 9'h020;
      return b;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_job = 0; m_done = 0; m_last = 1; m_client = 0; m_pos = 0;
         m_bytes.delete();
      end else if (m_done) begin
         m_done = 0;
      end else if (m_job) begin
         if (cmd_ready) begin
            m_pos++;
            if (m_pos == m_bytes.size()) begin
               m_job  = 0;
               m_done = 1;
            end
         end
      end else if (req0 || req1) begin
         m_client = (req0 && req1) ? !m_last : req1;
         m_last   = m_client;
         m_bytes.delete();
         m_pos = 0;
         if (!m_client) begin
            m_bytes.push_back({1'b0, 8'h80});
            for (int k = 3; k >= 0; k--) m_bytes.push_back({1'b1, asc(4'((number1 >> (4 * k)) & 16'hF))});
         end else begin
            m_bytes.push_back({1'b0, 8'hC0});
            m_bytes.push_back({1'b1, asc(number2)});
         end
         m_job = 1;
      end
   end

   // Compare process and byte logging, half a cycle away from the active edge.
   always @(negedge clk) begin
      chk("cmd_valid", {15'h0, cmd_valid}, {15'h0, m_job});
      chk("busy", {15'h0, busy}, {15'h0, (m_job || m_done)});
      chk("ack0", {15'h0, ack0}, {15'h0, (m_done && !m_client)});
      chk("ack1", {15'h0, ack1}, {15'h0, (m_done && m_client)});
      chk("lc_valid", {15'h0, lc_valid}, {15'h0, m_job});
      if (m_job) begin
         chk("cmd_byte", {7'h0, cmd_rs, cmd_data}, {7'h0, m_bytes[m_pos]});
         chk("lc_byte", {7'h0, lc_rs, lc_data}, {7'h0, lower(m_bytes[m_pos])});
      end
      if (reset && cmd_valid && cmd_ready) log_q.push_back({cmd_rs, cmd_data});
      if (reset && lc_valid && cmd_ready) lc_q.push_back({lc_rs, lc_data});
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input bit which, input int budget, output int n);
      n = 0;
      while (n < budget) begin
         tick();
         n++;
         if ((which ? ack1 : ack0) === 1'b1) return;
      end
      checks++;
      errors++;
      $display("FAIL ack%0d_timeout: none after %0d cycles", which, budget);
      n = -1;
   endtask

   task automatic expect_bytes(input string name, input logic [71:0] pk, input int n);
      logic [8:0] e;
      chk({name, "_count"}, 16'(log_q.size()), 16'(n));
      for (int i = 0; i < n; i++) begin
         e = pk[9 * (n - 1 - i) +: 9];
         chk(name, (i < log_q.size()) ? {7'h0, log_q[i]} : 16'hDEAD, {7'h0, e});
      end
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      log_q.delete();
      lc_q.delete();
   endtask

   int n;
   int g[$];

   initial begin
      // Reset values, checked before any clock edge.
      #3 reset = 1'b0;
      #1;
      chk("rst_valid", {15'h0, cmd_valid}, 16'h0);
      chk("rst_rs", {15'h0, cmd_rs}, 16'h0);
      chk("rst_data", {8'h0, cmd_data}, 16'h0);
      chk("rst_ack", {14'h0, ack1, ack0}, 16'h0);
      chk("rst_busy", {15'h0, busy}, 16'h0);
      repeat (2) tick();
      reset = 1'b1;

      // Client 0, value 0x0008.
      log_q.delete();
      req0 = 1; number1 = 16'h0008; cmd_ready = 1;
      tick();
      req0 = 0;
      wait_ack(0, 20, n);
      chk("ack0_latency", 16'(n + 1), 16'd6);
      tick();
      chk("busy_after", {15'h0, busy}, 16'h0);
      expect_bytes("t1_bytes", {9'h080, 9'h130, 9'h130, 9'h130, 9'h138}, 5);

      // Client 1, value 0xF, both letter cases.
      log_q.delete(); lc_q.delete();
      req1 = 1; number2 = 4'hF;
      tick();
      req1 = 0;
      wait_ack(1, 10, n);
      chk("ack1_latency", 16'(n + 1), 16'd3);
      expect_bytes("t2_bytes", {9'h0C0, 9'h146}, 2);
      chk("t2_lower", (lc_q.size() >= 2) ? {7'h0, lc_q[1]} : 16'hDEAD, 16'h166);
      tick();

      // Both requesting right after reset.
      pulse_reset();
      req0 = 1; req1 = 1; number1 = 16'hA1B2; number2 = 4'h7;
      repeat (24) tick();
      req0 = 0; req1 = 0;
      n = 0;
      while (busy && n < 20) begin tick(); n++; end
      chk("t3_idle", {15'h0, busy}, 16'h0);
      begin
         logic [71:0] pk;
         pk = {9'h080, 9'h141, 9'h131, 9'h142, 9'h132, 9'h0C0, 9'h137};
         for (int i = 0; i < 7; i++)
            chk("t3_bytes", (i < log_q.size()) ? {7'h0, log_q[i]} : 16'hDEAD, {7'h0, pk[9 * (6 - i) +: 9]});
      end
      g.delete();
      foreach (log_q[i]) if (!log_q[i][8]) g.push_back(log_q[i][7:0] == 8'hC0 ? 1 : 0);
      chk("t3_grants", 16'(g.size() >= 3), 16'h1);
      if (g.size() >= 3) begin
         chk("t3_grant0", 16'(g[0]), 16'h0);
         chk("t3_grant1", 16'(g[1]), 16'h1);
         chk("t3_grant2", 16'(g[2]), 16'h0);
      end

      // Backpressure on the second character, value change mid-job.
      log_q.delete();
      req0 = 1; number1 = 16'h1234;
      tick();
      req0 = 0; number1 = 16'hFFFF;
      tick();
      tick();
      cmd_ready = 0;
      chk("stall_data", {8'h0, cmd_data}, 16'h32);
      repeat (2) begin
         tick();
         chk("stall_data", {8'h0, cmd_data}, 16'h32);
      end
      cmd_ready = 1;
      chk("stall_data", {8'h0, cmd_data}, 16'h32);
      wait_ack(0, 20, n);
      expect_bytes("t4_bytes", {9'h080, 9'h131, 9'h132, 9'h133, 9'h134}, 5);
      tick();

      // Reset during the third character.
      req0 = 1; number1 = 16'hABCD;
      tick();
      req0 = 0;
      repeat (3) tick();
      #2 reset = 1'b0;
      #1;
      chk("async_valid", {15'h0, cmd_valid}, 16'h0);
      chk("async_busy", {15'h0, busy}, 16'h0);
      tick();
      reset = 1'b1;
      log_q.delete();
      req1 = 1; number2 = 4'h5;
      tick();
      req1 = 0;
      wait_ack(1, 10, n);
      expect_bytes("t5_bytes", {9'h0C0, 9'h135}, 2);

      // Random traffic, checked every cycle against the model.
      for (int c = 0; c < 3000; c++) begin
         tick();
         req0      = ($urandom_range(0, 3) != 0);
         req1      = ($urandom_range(0, 2) != 0);
         number1   = 16'($urandom);
         number2   = 4'($urandom);
         cmd_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 400) == 0) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
         end
      end
      req0 = 0; req1 = 0; cmd_ready = 1;
      repeat (10) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
